framebuffer_scanout: RTL and testbench
======================================

Name: framebuffer_scanout

Overview:
- Sink end of the pixel-plot interface: accepts (vga_x, vga_y, colour, plot) writes from the circle/fill drawing datapaths into an on-chip 160x120 framebuffer.
- On request, reads the framebuffer back in raster order as a valid/ready pixel stream, for frame readback, checksum or scan-out.
- Sits between the drawing FSM/datapath and the display/verification side.

Parameters:
- VGA_X_DW, 8, x coordinate width.
- VGA_Y_DW, 7, y coordinate width.
- COLOUR_DW, 3, colour width.
- H_PIXELS, 160, visible columns; valid x is 0..H_PIXELS-1.
- V_PIXELS, 120, visible rows; valid y is 0..V_PIXELS-1.

Ports:
- clk, in, 1, clock.
- resetn, in, 1, synchronous active-low reset.
- vga_x, in, VGA_X_DW, write x coordinate.
- vga_y, in, VGA_Y_DW, write y coordinate.
- vga_colour, in, COLOUR_DW, write colour.
- vga_plot, in, 1, write strobe, one pixel per cycle.
- start, in, 1, begin one raster readback.
- out_valid, out, 1, stream pixel valid.
- out_ready, in, 1, stream consumer ready.
- out_x, out, VGA_X_DW, x of presented pixel.
- out_y, out, VGA_Y_DW, y of presented pixel.
- out_colour, out, COLOUR_DW, colour of presented pixel.
- out_last, out, 1, high with pixel (H_PIXELS-1, V_PIXELS-1).
- busy, out, 1, readback (or clear) in progress.
- frame_done, out, 1, one-cycle pulse after the last handshake.

Behaviour:
- Reset is synchronous, active-low, on clk. It clears outputs and counters only; memory contents are not reset. Outputs after reset: out_valid=0, out_x=0, out_y=0, out_colour=0, out_last=0, busy=0, frame_done=0; FSM=IDLE.
- Memory: H_PIXELS*V_PIXELS words of COLOUR_DW; address = y*H_PIXELS + x. One write port, one read port with 1-cycle registered read latency.
- Write path, independent of FSM state:
  - When vga_plot=1 and x<H_PIXELS and y<V_PIXELS, mem[addr] <= vga_colour at the clock edge.
  - Out-of-range coordinates are silently dropped.
  - Writes continue during readback.
- Read/write collision: a read issued in the same cycle as a write to the same address returns the OLD data. The write is visible to reads issued from the next cycle on.
- FSM states: IDLE, FETCH, PRESENT, DONE.
- IDLE:
  - start=1 -> FETCH; load x=0, y=0; busy=1 from the next cycle.
- FETCH:
  - Read address for (x, y) presented to the RAM -> PRESENT.
- PRESENT:
  - out_valid=1; out_x/out_y/out_colour/out_last held stable until out_ready=1.
  - On handshake (out_valid & out_ready):
    - If last -> DONE.
    - Else advance: x+1; when x=H_PIXELS-1, x wraps to 0 and y+1. Then -> FETCH.
  - No handshake: stay in PRESENT; all outputs held.
- DONE:
  - frame_done=1 for exactly one cycle; busy=0 and FSM returns to IDLE on the next cycle.
- Timing:
  - start sampled in cycle 0 -> first out_valid in cycle 2.
  - With out_ready held high: 2 cycles per pixel, 2*H*V + 2 cycles from start to frame_done.
- start while busy or in DONE: ignored, no restart.
- out_last is 0 in every state except PRESENT on the final pixel.
- out_valid never drops without a handshake.
- Reset mid-readback: next cycle IDLE with all outputs at reset values; no frame_done pulse.

Optional Feature:
- Macro: FB_CLEAR_EN.
- With macro defined:
  - Adds input port clear (1 bit) and state CLEAR.
  - In IDLE, clear=1 (priority over start) -> CLEAR.
  - CLEAR writes 0 to addresses 0..H*V-1, one per cycle (19200 cycles at defaults), with busy=1, then returns directly to IDLE. No frame_done pulse.
  - vga_plot writes during CLEAR are dropped.
  - start and clear are ignored while busy.
- Without macro: no clear port, no CLEAR state; memory power-up contents are undefined (X in simulation).

Test Plan:
- Plot (0,0)=3'd5, (159,119)=3'd2, (10,20)=3'd7; start with out_ready=1 -> 19200 beats in raster order. Beat 0 colour 5, beat 20*160+10=3210 colour 7, beat 19199 colour 2 with out_last=1. frame_done exactly 38402 cycles after start.
- Plot (160,5) and (5,120) with colour 7, then read back -> addresses 5 and 120*... untouched; no beat shows a write of 7 at any wrapped or aliased address.
- Readback with out_ready toggling 1-of-3 cycles -> outputs stable while out_valid & !out_ready; sequence identical to the first test; no beat lost or duplicated.
- Same-cycle plot (x,y)=(4,0) colour 6 while FETCH reads address 4 (old value 1) -> beat 4 shows 1; a second readback shows 6.
- Assert resetn=0 at beat 500, start a new frame -> out_valid=0 and busy=0 in the cycle after reset, no frame_done; the new frame starts at (0,0).
- FB_CLEAR_EN: fill pixels with 3'd7, pulse clear -> busy high 19200 cycles; a plot during clear is dropped; the following readback is all zeros.

Source files
------------

// File: rtl/framebuffer_scanout.sv
// +----------------------------------------------------------------------------+
// | Module      : framebuffer_scanout                                          |
// | Description : 160x120 pixel framebuffer with a plot write port and a       |
// |               raster-order valid/ready readback stream. Define FB_CLEAR_EN |
// |               to add a clear port that zero-fills the framebuffer.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module framebuffer_scanout #(
    parameter int VGA_X_DW  = 8,
    parameter int VGA_Y_DW  = 7,
    parameter int COLOUR_DW = 3,
    parameter int H_PIXELS  = 160,
    parameter int V_PIXELS  = 120
) (
    input  logic                 clk,
    input  logic                 resetn,
`ifdef FB_CLEAR_EN
    input  logic                 clear,
`endif
    input  logic [VGA_X_DW-1:0]  vga_x,
    input  logic [VGA_Y_DW-1:0]  vga_y,
    input  logic [COLOUR_DW-1:0] vga_colour,
    input  logic                 vga_plot,
    input  logic                 start,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [VGA_X_DW-1:0]  out_x,
    output logic [VGA_Y_DW-1:0]  out_y,
    output logic [COLOUR_DW-1:0] out_colour,
    output logic                 out_last,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned C_NPIX  = H_PIXELS * V_PIXELS;
    localparam int          C_ADDR_W = $clog2(C_NPIX);

    localparam logic [VGA_X_DW:0]   C_H_LIM  = (VGA_X_DW+1)'(H_PIXELS);
    localparam logic [VGA_Y_DW:0]   C_V_LIM  = (VGA_Y_DW+1)'(V_PIXELS);
    localparam logic [VGA_X_DW-1:0] C_X_MAX  = VGA_X_DW'(H_PIXELS - 1);
    localparam logic [VGA_Y_DW-1:0] C_Y_MAX  = VGA_Y_DW'(V_PIXELS - 1);
    localparam logic [C_ADDR_W-1:0] C_H_MUL  = C_ADDR_W'(H_PIXELS);
    localparam logic [C_ADDR_W-1:0] C_A_MAX  = C_ADDR_W'(C_NPIX - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_PRESENT = 3'd2,
        S_DONE    = 3'd3
`ifdef FB_CLEAR_EN
        ,
        S_CLEAR   = 3'd4
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [VGA_X_DW-1:0]   x_q, x_d;
    logic [VGA_Y_DW-1:0]   y_q, y_d;
    logic                  frame_done_q;
    logic [COLOUR_DW-1:0]  rd_colour_q;
    logic [COLOUR_DW-1:0]  mem_q [C_NPIX];
`ifdef FB_CLEAR_EN
    logic [C_ADDR_W-1:0]   clr_addr_q, clr_addr_d;
`endif

    logic                  w_last;
    logic                  w_re;
    logic [C_ADDR_W-1:0]   w_rd_addr;
    logic                  w_we;
    logic [C_ADDR_W-1:0]   w_wr_addr;
    logic [COLOUR_DW-1:0]  w_wr_data;
    logic                  w_plot_ok;

    assign w_last    = (x_q == C_X_MAX) && (y_q == C_Y_MAX);
    assign w_re      = (state_q == S_FETCH);
    assign w_rd_addr = C_ADDR_W'(y_q) * C_H_MUL + C_ADDR_W'(x_q);
    assign w_plot_ok = vga_plot && ({1'b0, vga_x} < C_H_LIM) && ({1'b0, vga_y} < C_V_LIM);

    // The clear sweep owns the write port; plots arriving meanwhile are lost.
    always_comb begin
        w_we      = w_plot_ok;
        w_wr_addr = C_ADDR_W'(vga_y) * C_H_MUL + C_ADDR_W'(vga_x);
        w_wr_data = vga_colour;
`ifdef FB_CLEAR_EN
        if (state_q == S_CLEAR) begin
            w_we      = 1'b1;
            w_wr_addr = clr_addr_q;
            w_wr_data = '0;
        end
`endif
    end

    // Read and write share one edge, so a same-address read returns old data.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[w_wr_addr] <= w_wr_data;
        end
        if (w_re) begin
            rd_colour_q <= mem_q[w_rd_addr];
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
`ifdef FB_CLEAR_EN
        clr_addr_d = clr_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef FB_CLEAR_EN
                if (clear) begin
                    state_d    = S_CLEAR;
                    clr_addr_d = '0;
                end else
`endif
                if (start) begin
                    state_d = S_FETCH;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_FETCH: begin
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (out_ready) begin
                    if (w_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        if (x_q == C_X_MAX) begin
                            x_d = '0;
                            y_d = y_q + VGA_Y_DW'(1);
                        end else begin
                            x_d = x_q + VGA_X_DW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
`ifdef FB_CLEAR_EN
            S_CLEAR: begin
                if (clr_addr_q == C_A_MAX) begin
                    state_d = S_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + C_ADDR_W'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
`ifdef FB_CLEAR_EN
            clr_addr_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= (state_q == S_DONE);
`ifdef FB_CLEAR_EN
            clr_addr_q   <= clr_addr_d;
`endif
        end
    end

    assign out_valid  = (state_q == S_PRESENT);
    assign out_x      = x_q;
    assign out_y      = y_q;
    assign out_colour = out_valid ? rd_colour_q : '0;
    assign out_last   = out_valid && w_last;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_framebuffer_scanout.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_framebuffer_scanout                                       |
// | Description : Directed bench for framebuffer_scanout with a raster model.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_framebuffer_scanout;

    localparam int H = 160;
    localparam int V = 120;
    localparam int N = H * V;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] vga_x = '0;
    logic [6:0] vga_y = '0;
    logic [2:0] vga_colour = '0;
    logic       vga_plot = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       out_last;
    logic       busy;
    logic       frame_done;
`ifdef FB_CLEAR_EN
    logic       clear = 1'b0;
`endif

    always #5 clk = ~clk;

    framebuffer_scanout dut (
        .clk        (clk),
        .resetn     (resetn),
`ifdef FB_CLEAR_EN
        .clear      (clear),
`endif
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .start      (start),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_colour (out_colour),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Model: memory image plus the beat currently owed to the consumer.
    logic [2:0] m_mem [N];
    bit   m_init = 0, m_busy = 0, m_valid = 0, m_fetch = 0, m_done1 = 0, m_fd = 0;
    int   m_k = 0;
    int   m_col = 0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_init = 1; m_busy = 0; m_valid = 0; m_fetch = 0; m_done1 = 0; m_fd = 0; m_k = 0;
        end else begin
            m_fd = 0;
            if (m_done1) begin
                m_done1 = 0; m_busy = 0; m_fd = 1;
            end else if (!m_busy) begin
                if (start) begin m_busy = 1; m_k = 0; m_fetch = 1; end
            end else if (m_fetch) begin
                m_fetch = 0; m_valid = 1; m_col = int'(m_mem[m_k]);
            end else if (m_valid && out_ready) begin
                m_valid = 0;
                if (m_k == N - 1) m_done1 = 1;
                else begin m_k++; m_fetch = 1; end
            end
        end
        if (vga_plot && int'(vga_x) < H && int'(vga_y) < V)
            m_mem[int'(vga_y) * H + int'(vga_x)] = vga_colour;
    end

    int   hs = 0;
    logic [2:0] seen_col [N];
    bit   seen_last [N];
    bit   p_ok = 0, p_v = 0, p_r = 0, p_l = 0;
    int   p_x = 0, p_y = 0, p_c = 0;

    always @(negedge clk) begin
        if (m_init) begin
            chk("valid", int'(out_valid), int'(m_valid));
            chk("busy", int'(busy), int'(m_busy));
            chk("frame_done", int'(frame_done), int'(m_fd));
            chk("last", int'(out_last), int'(m_valid && m_k == N - 1));
            if (m_valid) begin
                chk("x", int'(out_x), m_k % H);
                chk("y", int'(out_y), m_k / H);
                chk("colour", int'(out_colour), m_col);
            end
            if (p_ok && p_v && !p_r) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_x", int'(out_x), p_x);
                chk("hold_y", int'(out_y), p_y);
                chk("hold_colour", int'(out_colour), p_c);
                chk("hold_last", int'(out_last), int'(p_l));
            end
        end
        p_ok = resetn; p_v = out_valid; p_r = out_ready; p_l = out_last;
        p_x = int'(out_x); p_y = int'(out_y); p_c = int'(out_colour);
        if (!resetn) hs = 0;
        else begin
            if (out_valid && out_ready && hs < N) begin
                seen_col[hs] = out_colour; seen_last[hs] = out_last; hs++;
            end
            if (frame_done) hs = 0;
        end
    end

    logic [2:0] ref_col [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plot(input int x, input int y, input int c);
        vga_plot = 1'b1; vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(c);
        tick();
        vga_plot = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, input bit toggle);
        int cyc = 0;
        while (hs < n && cyc < budget) begin
            if (toggle) out_ready = (cyc % 3 == 0);
            tick();
            cyc++;
        end
        chk("beats_reached", int'(hs >= n), 1);
        out_ready = 1'b1;
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        tick();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_x", int'(out_x), 0);
        chk("rst_y", int'(out_y), 0);
        chk("rst_colour", int'(out_colour), 0);
        chk("rst_last", int'(out_last), 0);
        resetn = 1'b1;
    endtask

    initial begin
        int cyc;
        repeat (2) tick();
        pulse_reset();

        // Known background so every beat has a defined expectation.
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                plot(x, y, (x + y) % 8);
        plot(0, 0, 5);
        plot(159, 119, 2);
        plot(10, 20, 7);
        plot(4, 0, 1);
        plot(160, 5, 7);
        plot(5, 120, 7);

        // Full frame, ready held high; stray starts while busy and in DONE.
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!frame_done && cyc < 40000) begin
            start = (cyc == 1000 || cyc == 38401);
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("frame_done_cycle", cyc, 38402);
        chk("beat_count", hs, N);
        chk("beat0_colour", int'(seen_col[0]), 5);
        chk("beat3210_colour", int'(seen_col[3210]), 7);
        chk("beat19199_colour", int'(seen_col[N-1]), 2);
        chk("beat19199_last", int'(seen_last[N-1]), 1);
        chk("beat19198_last", int'(seen_last[N-2]), 0);
        chk("beat5_colour", int'(seen_col[5]), 5);
        chk("beat800_colour", int'(seen_col[800]), 5);
        chk("beat960_colour", int'(seen_col[960]), 6);
        chk("beat4_colour", int'(seen_col[4]), 1);
        for (int k = 0; k < N; k++) ref_col[k] = seen_col[k];
        tick();
        chk("no_restart_busy", int'(busy), 0);

        // Backpressured readback, then reset at beat 500.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_beats(500, 5000, 1'b1);
        for (int k = 0; k < 500; k++) chk("bp_sequence", int'(seen_col[k]), int'(ref_col[k]));
        pulse_reset();
        repeat (3) begin
            tick();
            chk("post_rst_no_done", int'(frame_done), 0);
        end

        // Write to (4,0) in the same cycle beat 4 is fetched.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("first_valid_cycle2", int'(out_valid), 1);
        chk("first_x", int'(out_x), 0);
        chk("first_y", int'(out_y), 0);
        repeat (7) tick();
        plot(4, 0, 6);
        wait_beats(10, 100, 1'b0);
        chk("collision_old", int'(seen_col[4]), 1);
        pulse_reset();

        start = 1'b1;
        tick();
        start = 1'b0;
        wait_beats(10, 100, 1'b0);
        chk("collision_new", int'(seen_col[4]), 6);
        pulse_reset();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
